// File: rtl/player_motion.sv
// Player movement controller: button presses become a grid cell, a facing direction and
// an animated pixel centre. Translations are gated by a wall lookup to the maze store.
module player_motion #(
  parameter int         TILE_SIZE = 32,
  parameter int         GRID_W    = 16,
  parameter int         GRID_H    = 12,
  parameter int         ORIGIN_X  = 0,
  parameter int         ORIGIN_Y  = 0,
  parameter int         STEP_PX   = 2,
  parameter int         START_COL = 1,
  parameter int         START_ROW = 1,
  parameter logic [1:0] START_DIR = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_fwd,
  input  logic        btn_back,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        wall_req,
  output logic [4:0]  wall_col,
  output logic [4:0]  wall_row,
  output logic [1:0]  wall_dir,
  input  logic        wall_ack,
  input  logic        wall_blocked,
  output logic [10:0] player_px,
  output logic [10:0] player_py,
  output logic [1:0]  dir,
  output logic        moving,
  output logic        bump
);

  // Direction encoding: turning left is +1 mod 4, right is -1, opposite is +2.
  localparam logic [1:0] DIR_EAST  = 2'd0;
  localparam logic [1:0] DIR_NORTH = 2'd1;
  localparam logic [1:0] DIR_WEST  = 2'd2;
  localparam logic [1:0] DIR_SOUTH = 2'd3;

  typedef enum logic [1:0] {IDLE, QUERY, MOVE} state_t;

  state_t             state;
  logic [4:0]         col, row;
  logic [1:0]         mdir;
  logic signed [11:0] offset;
  logic               prev_left, prev_right;

  logic               turn_l, turn_r, translate, at_edge, done;
  logic [1:0]         req_dir;
  logic [11:0]        abs_off;
  logic signed [11:0] step;
  logic [4:0]         tgt_col, tgt_row;
  logic [12:0]        off_ext, x_calc, y_calc;

  always_comb begin
    turn_l    = btn_left  & ~btn_right & ~prev_left;
    turn_r    = btn_right & ~btn_left  & ~prev_right;
    translate = btn_fwd ^ btn_back;
    req_dir   = btn_back ? dir + 2'd2 : dir;
    at_edge   = 1'b0;
    case (req_dir)
      DIR_EAST:  at_edge = (col == 5'(GRID_W - 1));
      DIR_NORTH: at_edge = (row == 5'd0);
      DIR_WEST:  at_edge = (col == 5'd0);
      DIR_SOUTH: at_edge = (row == 5'(GRID_H - 1));
      default:   at_edge = 1'b0;
    endcase
    tgt_col = col;
    tgt_row = row;
    case (mdir)
      DIR_EAST:  tgt_col = col + 5'd1;
      DIR_NORTH: tgt_row = row - 5'd1;
      DIR_WEST:  tgt_col = col - 5'd1;
      DIR_SOUTH: tgt_row = row + 5'd1;
      default:   tgt_col = col;
    endcase
    abs_off = offset[11] ? -offset : offset;
    // Screen y grows downward, so SOUTH shares the positive step with EAST.
    step    = (mdir == DIR_EAST || mdir == DIR_SOUTH) ? 12'(STEP_PX) : -12'(STEP_PX);
    done    = abs_off >= 12'(TILE_SIZE - STEP_PX);
    off_ext = {offset[11], offset};
    x_calc  = 13'(ORIGIN_X + TILE_SIZE / 2) + 13'(col) * 13'(TILE_SIZE)
              + (mdir[0] ? 13'd0 : off_ext);
    y_calc  = 13'(ORIGIN_Y + TILE_SIZE / 2) + 13'(row) * 13'(TILE_SIZE)
              + (mdir[0] ? off_ext : 13'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= 5'(START_COL);
      row        <= 5'(START_ROW);
      dir        <= START_DIR;
      mdir       <= START_DIR;
      offset     <= '0;
      prev_left  <= 1'b0;
      prev_right <= 1'b0;
      wall_req   <= 1'b0;
      wall_col   <= '0;
      wall_row   <= '0;
      wall_dir   <= '0;
      moving     <= 1'b0;
      bump       <= 1'b0;
      player_px  <= 11'(ORIGIN_X + START_COL * TILE_SIZE + TILE_SIZE / 2);
      player_py  <= 11'(ORIGIN_Y + START_ROW * TILE_SIZE + TILE_SIZE / 2);
    end else begin
      bump      <= 1'b0;
      player_px <= x_calc[10:0];
      player_py <= y_calc[10:0];
      if (frame_tick) begin
        prev_left  <= btn_left;
        prev_right <= btn_right;
      end
      case (state)
        IDLE: if (frame_tick) begin
          if (turn_l)      dir <= dir + 2'd1;
          else if (turn_r) dir <= dir - 2'd1;
          else if (translate) begin
            if (at_edge) bump <= 1'b1;
            else begin
              state    <= QUERY;
              wall_req <= 1'b1;
              wall_col <= col;
              wall_row <= row;
              wall_dir <= req_dir;
              mdir     <= req_dir;
            end
          end
        end
        QUERY: if (wall_ack) begin
          wall_req <= 1'b0;
          if (wall_blocked) begin
            bump  <= 1'b1;
            state <= IDLE;
          end else begin
            moving <= 1'b1;
            state  <= MOVE;
          end
        end
        MOVE: if (frame_tick) begin
          // Arrival commits cell and clears offset on the same edge so px never jumps back.
          if (done) begin
            col    <= tgt_col;
            row    <= tgt_row;
            offset <= '0;
            moving <= 1'b0;
            state  <= IDLE;
          end else begin
            offset <= offset + step;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: expected queries, pixel positions and facings are
// queued when stimulus is applied and popped when the DUT responds.
module tb_player_motion;
  localparam logic [1:0] EAST = 2'd0, NORTH = 2'd1, WEST = 2'd2;

  logic clk = 0, rst = 1, frame_tick = 0;
  logic btn_fwd = 0, btn_back = 0, btn_left = 0, btn_right = 0;
  logic wall_ack = 0, wall_blocked = 0;
  logic wall_req, moving, bump;
  logic [4:0] wall_col, wall_row;
  logic [1:0] wall_dir, dir;
  logic [10:0] player_px, player_py;

  // Second instance parked on the west edge of the maze, facing WEST.
  logic e_fwd = 0, e_back = 0, e_ack = 0, e_blocked = 0;
  logic e_req, e_moving, e_bump;
  logic [4:0] e_col, e_row;
  logic [1:0] e_wdir, e_dir;
  logic [10:0] e_px, e_py;

  int vecs = 0, errs = 0;
  logic [11:0] qq[$];
  logic [10:0] pq[$];
  logic [1:0]  dq[$];

  always #5 clk = ~clk;

  player_motion u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_fwd(btn_fwd), .btn_back(btn_back), .btn_left(btn_left), .btn_right(btn_right),
    .wall_req(wall_req), .wall_col(wall_col), .wall_row(wall_row), .wall_dir(wall_dir),
    .wall_ack(wall_ack), .wall_blocked(wall_blocked),
    .player_px(player_px), .player_py(player_py), .dir(dir), .moving(moving), .bump(bump)
  );

  player_motion #(.START_COL(0), .START_DIR(2'd2)) u_edge (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_fwd(e_fwd), .btn_back(e_back), .btn_left(1'b0), .btn_right(1'b0),
    .wall_req(e_req), .wall_col(e_col), .wall_row(e_row), .wall_dir(e_wdir),
    .wall_ack(e_ack), .wall_blocked(e_blocked),
    .player_px(e_px), .player_py(e_py), .dir(e_dir), .moving(e_moving), .bump(e_bump)
  );

  task automatic do_reset();
    btn_fwd = 0; btn_back = 0; btn_left = 0; btn_right = 0;
    wall_ack = 0; wall_blocked = 0; e_fwd = 0; e_back = 0; e_ack = 0; e_blocked = 0;
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic do_tick();
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
  endtask

  task automatic serve_query(input logic blk, input int dly, output logic got_bump,
                             output logic got_moving);
    logic [11:0] exp;
    int n = 0;
    exp = (qq.size() > 0) ? qq.pop_front() : 12'hfff;
    while (!wall_req && n < 20) begin @(negedge clk); n++; end
    got_bump = 0; got_moving = 0;
    vecs++;
    if (wall_req !== 1'b1) begin
      errs++; $display("FAIL query_timeout wall_req=%b want 1", wall_req);
    end else begin
      vecs++;
      if ({wall_col, wall_row, wall_dir} !== exp) begin
        errs++; $display("FAIL query_fields got %h want %h", {wall_col, wall_row, wall_dir}, exp);
      end
      repeat (dly) @(negedge clk);
      vecs++;
      if (wall_req !== 1'b1 || {wall_col, wall_row, wall_dir} !== exp) begin
        errs++; $display("FAIL query_hold req=%b fields %h want 1 %h",
                         wall_req, {wall_col, wall_row, wall_dir}, exp);
      end
      wall_ack = 1; wall_blocked = blk;
      @(negedge clk);
      wall_ack = 0; wall_blocked = 0;
      got_bump = bump; got_moving = moving;
      vecs++;
      if (wall_req !== 1'b0) begin
        errs++; $display("FAIL query_drop wall_req=%b want 0", wall_req);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({player_px, player_py, dir, moving, wall_req, bump} !== {11'd48, 11'd48, EAST, 3'b000}) begin
      errs++; $display("FAIL reset px=%0d py=%0d dir=%0d mv=%b req=%b bump=%b want 48 48 0 0 0 0",
                       player_px, player_py, dir, moving, wall_req, bump);
    end
  endtask

  task automatic test_forward();
    logic b, m;
    do_reset();
    btn_fwd = 1; qq.push_back({5'd1, 5'd1, EAST});
    do_tick();
    btn_fwd = 0;
    serve_query(1'b0, 3, b, m);
    vecs++;
    if (b !== 1'b0 || m !== 1'b1) begin
      errs++; $display("FAIL fwd_ack bump=%b moving=%b want 0 1", b, m);
    end
    for (int k = 1; k <= 16; k++) begin
      pq.push_back(11'(48 + 2 * k));
      do_tick();
      @(negedge clk);
      vecs++;
      if (player_px !== pq[0] || player_py !== 11'd48) begin
        errs++; $display("FAIL fwd_px tick %0d px=%0d py=%0d want %0d 48", k, player_px, player_py, pq[0]);
      end
      void'(pq.pop_front());
      if (k == 1 || k == 16) begin
        vecs++;
        if (moving !== (k == 1)) begin
          errs++; $display("FAIL fwd_moving tick %0d moving=%b want %b", k, moving, k == 1);
        end
      end
    end
    btn_fwd = 1; qq.push_back({5'd2, 5'd1, EAST});
    do_tick();
    btn_fwd = 0;
    serve_query(1'b1, 1, b, m);
    vecs++;
    if (b !== 1'b1 || m !== 1'b0 || player_px !== 11'd80) begin
      errs++; $display("FAIL fwd2_blocked bump=%b moving=%b px=%0d want 1 0 80", b, m, player_px);
    end
  endtask

  task automatic test_blocked();
    logic b, m;
    int bumps = 0, movs = 0;
    do_reset();
    btn_fwd = 1; qq.push_back({5'd1, 5'd1, EAST});
    do_tick();
    btn_fwd = 0;
    serve_query(1'b1, 3, b, m);
    bumps += b; movs += m;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bumps += bump; movs += moving;
    end
    vecs++;
    if (bumps != 1 || movs != 0 || player_px !== 11'd48) begin
      errs++; $display("FAIL blocked bumps=%0d moving_cycles=%0d px=%0d want 1 0 48", bumps, movs, player_px);
    end
  endtask

  task automatic test_turn();
    do_reset();
    btn_left = 1;
    dq.push_back(NORTH); dq.push_back(NORTH); dq.push_back(NORTH);
    for (int k = 0; k < 3; k++) begin
      do_tick();
      vecs++;
      if (dir !== dq[0]) begin
        errs++; $display("FAIL turn_left_held tick %0d dir=%0d want %0d", k, dir, dq[0]);
      end
      void'(dq.pop_front());
    end
    btn_left = 0; do_tick();
    btn_left = 1; btn_right = 1; dq.push_back(NORTH);
    do_tick();
    vecs++;
    if (dir !== dq[0]) begin
      errs++; $display("FAIL turn_both dir=%0d want %0d", dir, dq[0]);
    end
    void'(dq.pop_front());
    btn_left = 0; btn_right = 0; do_tick();
    btn_right = 1; dq.push_back(EAST);
    do_tick();
    btn_right = 0;
    vecs++;
    if (dir !== dq[0] || wall_req !== 1'b0) begin
      errs++; $display("FAIL turn_right dir=%0d req=%b want %0d 0", dir, wall_req, dq[0]);
    end
    void'(dq.pop_front());
  endtask

  task automatic test_edge();
    logic [11:0] exp;
    int n = 0;
    do_reset();
    vecs++;
    if (e_px !== 11'd16 || e_dir !== WEST) begin
      errs++; $display("FAIL edge_reset px=%0d dir=%0d want 16 2", e_px, e_dir);
    end
    e_fwd = 1;
    do_tick();
    e_fwd = 0;
    vecs++;
    if (e_bump !== 1'b1 || e_req !== 1'b0) begin
      errs++; $display("FAIL edge_fwd bump=%b req=%b want 1 0", e_bump, e_req);
    end
    @(negedge clk);
    vecs++;
    if (e_bump !== 1'b0 || e_req !== 1'b0) begin
      errs++; $display("FAIL edge_fwd_pulse bump=%b req=%b want 0 0", e_bump, e_req);
    end
    e_back = 1; qq.push_back({5'd0, 5'd1, EAST});
    do_tick();
    e_back = 0;
    exp = qq.pop_front();
    while (!e_req && n < 20) begin @(negedge clk); n++; end
    vecs++;
    if (e_req !== 1'b1 || {e_col, e_row, e_wdir} !== exp || e_dir !== WEST) begin
      errs++; $display("FAIL edge_back req=%b fields %h dir=%0d want 1 %h 2",
                       e_req, {e_col, e_row, e_wdir}, exp, e_dir);
    end
    e_ack = 1; e_blocked = 1;
    @(negedge clk);
    e_ack = 0; e_blocked = 0;
  endtask

  task automatic test_reset_mid_move();
    logic b, m;
    do_reset();
    btn_fwd = 1; qq.push_back({5'd1, 5'd1, EAST});
    do_tick();
    btn_fwd = 0;
    serve_query(1'b0, 2, b, m);
    repeat (8) do_tick();
    @(negedge clk);
    vecs++;
    if (player_px !== 11'd64 || moving !== 1'b1) begin
      errs++; $display("FAIL mid_move px=%0d moving=%b want 64 1", player_px, moving);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    vecs++;
    if (player_px !== 11'd48 || moving !== 1'b0 || wall_req !== 1'b0 || bump !== 1'b0) begin
      errs++; $display("FAIL rst_mid_move px=%0d mv=%b req=%b bump=%b want 48 0 0 0",
                       player_px, moving, wall_req, bump);
    end
    btn_fwd = 1; qq.push_back({5'd1, 5'd1, EAST});
    do_tick();
    btn_fwd = 0;
    serve_query(1'b1, 1, b, m);
  endtask

  task automatic test_back_to_back();
    logic b, m;
    do_reset();
    btn_fwd = 1; qq.push_back({5'd1, 5'd1, EAST});
    do_tick();
    serve_query(1'b0, 1, b, m);
    repeat (16) do_tick();
    vecs++;
    if (moving !== 1'b0 || wall_req !== 1'b0) begin
      errs++; $display("FAIL b2b_arrive moving=%b req=%b want 0 0", moving, wall_req);
    end
    qq.push_back({5'd2, 5'd1, EAST});
    do_tick();
    btn_fwd = 0;
    serve_query(1'b1, 0, b, m);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_blocked();
    test_turn();
    test_edge();
    test_reset_mid_move();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
